// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Registered execute stage fed by the ALU control decoder. Logic and
// arithmetic ops produce their registered result one cycle after acceptance.
// Shifts go through a 1-bit-per-cycle serial shifter, so the datapath needs
// no barrel shifter. A shift by N delivers its result N cycles after
// acceptance. A shift by 0 or 1 completes in a single cycle.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    request valid
//   in_ready    stage can accept a request this cycle (independent of in_valid)
//   ALUcontrol  4-bit op code
//   alu_a       operand A
//   alu_b       operand B; the shift amount is alu_b[SHAMT_W-1:0]
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   result      registered result
//   zero        result == 0, registered with result
//   illegal_op  unrecognised op code, registered with result
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUcontrol,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shdir_t;

    state_t               r_state;
    state_t               w_next_state;
    shdir_t               r_shdir;
    shdir_t               w_shdir_in;
    shdir_t               w_sh_dir;
    logic [XLEN-1:0]      r_shreg;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic                 r_illegal;
    logic                 r_out_valid;

    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_accept;
    logic                 w_is_shift;
    logic [XLEN-1:0]      w_alu_res;
    logic                 w_alu_illegal;
    logic [XLEN-1:0]      w_sh_src;
    logic [XLEN-1:0]      w_sh_one;
    logic                 w_start_shift;
    logic                 w_load_result;
    logic [XLEN-1:0]      w_new_result;
    logic                 w_new_illegal;

    assign w_shamt  = alu_b[SHAMT_W-1:0];
    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Single-cycle ops and op classification.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_alu_res     = '0;
        w_alu_illegal = 1'b0;
        w_is_shift    = 1'b0;
        w_shdir_in    = SH_SLL;
        case (ALUcontrol)
            OP_AND: w_alu_res = alu_a & alu_b;
            OP_OR:  w_alu_res = alu_a | alu_b;
            OP_ADD: w_alu_res = alu_a + alu_b;
            OP_SUB: w_alu_res = alu_a - alu_b;
            OP_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_NOR: w_alu_res = ~(alu_a | alu_b);
            OP_SLL: begin
                w_is_shift = 1'b1;
                w_shdir_in = SH_SLL;
            end
            OP_SRL: begin
                w_is_shift = 1'b1;
                w_shdir_in = SH_SRL;
            end
            OP_SRA: begin
                w_is_shift = 1'b1;
                w_shdir_in = SH_SRA;
            end
            default: w_alu_illegal = 1'b1;
        endcase
    end

    // One shared 1-bit shifter. In IDLE it shifts the incoming operand, so the
    // first shift step is done at the accept edge. In SHIFT it advances the
    // shift register. This is what makes a shift by N take exactly N cycles.
    assign w_sh_src = (r_state == S_SHIFT) ? r_shreg : alu_a;
    assign w_sh_dir = (r_state == S_SHIFT) ? r_shdir : w_shdir_in;

    always_comb begin
        case (w_sh_dir)
            SH_SRL:  w_sh_one = {1'b0, w_sh_src[XLEN-1:1]};
            SH_SRA:  w_sh_one = {w_sh_src[XLEN-1], w_sh_src[XLEN-1:1]};
            default: w_sh_one = {w_sh_src[XLEN-2:0], 1'b0};
        endcase
    end

    // FSM next-state and result-load control
    always_comb begin
        w_next_state  = r_state;
        w_start_shift = 1'b0;
        w_load_result = 1'b0;
        w_new_result  = w_alu_res;
        w_new_illegal = w_alu_illegal;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load_result = 1'b1;
                    if (w_is_shift) begin
                        if (w_shamt == '0) begin
                            w_new_result = alu_a;
                        end else if (w_shamt == SHAMT_W'(1)) begin
                            w_new_result = w_sh_one;
                        end else begin
                            w_load_result = 1'b0;
                            w_start_shift = 1'b1;
                            w_next_state  = S_SHIFT;
                        end
                    end
                end
            end
            S_SHIFT: begin
                // Inputs are don't-care here, so the decoder's illegal flag is ignored.
                w_new_illegal = 1'b0;
                w_new_result  = w_sh_one;
                if (r_cnt == SHAMT_W'(1)) begin
                    w_load_result = 1'b1;
                    w_next_state  = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values present before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_shdir     <= SH_SLL;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // r_cnt holds the number of shift steps still to do. It counts the
            // step taken on the edge where r_cnt == 1.
            if (w_start_shift) begin
                r_shreg <= w_sh_one;
                r_cnt   <= w_shamt - SHAMT_W'(1);
                r_shdir <= w_shdir_in;
            end else if (r_state == S_SHIFT) begin
                r_shreg <= w_sh_one;
                r_cnt   <= r_cnt - SHAMT_W'(1);
            end

            if (w_load_result) begin
                r_result    <= w_new_result;
                r_zero      <= (w_new_result == '0);
                r_illegal   <= w_new_illegal;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero       = r_zero;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Self-checking bench for alu_exec_stage. A transaction-level model computes
// each result with plain SV operators and tracks the following:
//   - whether a result is pending,
//   - how many cycles remain before a serial shift completes.
// A single compare process checks the DUT against this model on every falling
// edge. Directed sequences add literal expectations, and a randomized phase
// follows them.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALUcontrol;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal_op;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUcontrol (ALUcontrol),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  = 1'b0;
    logic [31:0] m_result = '0;
    bit          m_zero   = 1'b0;
    bit          m_ill    = 1'b0;
    int          m_busy   = 0;    // cycles until a pending shift result appears
    logic [31:0] m_pend   = '0;

    function automatic bit m_ready();
        return (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    // Result, illegal flag and latency (cycles from accept to out_valid)
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        res = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            4'b1000: begin res = a << sh;                      lat = (sh == 0) ? 1 : sh; end
            4'b1001: begin res = a >> sh;                      lat = (sh == 0) ? 1 : sh; end
            4'b1010: begin res = $unsigned($signed(a) >>> sh); lat = (sh == 0) ? 1 : sh; end
            default: ill = 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_busy   = 0;
            m_result = '0;
            m_zero   = 1'b0;
            m_ill    = 1'b0;
        end else begin
            bit          acc;
            logic [31:0] r;
            bit          il;
            int          lat;
            acc = in_valid && m_ready();
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid  = 1'b1;
                    m_result = m_pend;
                    m_zero   = (m_pend == 0);
                    m_ill    = 1'b0;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                ref_op(ALUcontrol, alu_a, alu_b, r, il, lat);
                if (lat == 1) begin
                    m_valid  = 1'b1;
                    m_result = r;
                    m_zero   = (r == 0);
                    m_ill    = il;
                end else begin
                    m_busy = lat - 1;
                    m_pend = r;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
            check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("cmp_result", result, m_result);
                check("cmp_zero", 32'(zero), 32'(m_zero));
                check("cmp_illegal", 32'(illegal_op), 32'(m_ill));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        ALUcontrol = op;
        alu_a      = a;
        alu_b      = b;
    endtask

    // Holds the request until it is accepted (bounded), then drops in_valid.
    task automatic accept_wait(input string name);
        int waited;
        waited = 0;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #3;
            waited++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #2;
        drive(op, a, b);
        accept_wait(name);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                             4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111, 4'b1101};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ALUcontrol = 4'b0000;
        alu_a      = '0;
        alu_b      = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // 1: ADD overflow wraps
        issue("t1", 4'b0010, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_result", result, 32'h8000_0000);
        check("t1_zero", 32'(zero), 32'd0);

        // 2: SUB then SLT back-to-back
        issue("t2a", 4'b0110, 32'd5, 32'd5);
        @(negedge clk);
        check("t2_sub_result", result, 32'd0);
        check("t2_sub_zero", 32'(zero), 32'd1);
        check("t2_ready", 32'(in_ready), 32'd1);
        #2 drive(4'b0111, 32'hFFFF_FFFF, 32'd1);
        accept_wait("t2b");
        @(negedge clk);
        check("t2_slt_valid", 32'(out_valid), 32'd1);
        check("t2_slt_result", result, 32'd1);
        check("t2_slt_zero", 32'(zero), 32'd0);

        // 3: SRA by 4, serial
        issue("t3", 4'b1010, 32'h8000_0010, 32'd4);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t3_busy_ready_c%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("t3_busy_valid_c%0d", k), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("t3_sra_valid", 32'(out_valid), 32'd1);
        check("t3_sra_result", result, 32'hF800_0001);
        check("t3_sra_ready", 32'(in_ready), 32'd1);
        // SLL by 0: only the low 5 bits of b count
        issue("t3b", 4'b1000, 32'h1234_5678, 32'hFFFF_FFE0);
        @(negedge clk);
        check("t3_sll0_valid", 32'(out_valid), 32'd1);
        check("t3_sll0_result", result, 32'h1234_5678);

        // 4: backpressure
        @(negedge clk);
        #2 out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd2);
        accept_wait("t4");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_result", result, 32'd3);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        #2 out_ready = 1'b1;
        #1 check("t4_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("t4_valid_dropped", 32'(out_valid), 32'd0);
        check("t4_ready_after", 32'(in_ready), 32'd1);

        // 5: illegal code, then AND clears the flag
        issue("t5a", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        check("t5_ill_result", result, 32'd0);
        check("t5_ill_zero", 32'(zero), 32'd1);
        check("t5_ill_flag", 32'(illegal_op), 32'd1);
        issue("t5b", 4'b0000, 32'h0000_00F0, 32'h0000_003C);
        @(negedge clk);
        check("t5_and_result", result, 32'h0000_0030);
        check("t5_and_illegal", 32'(illegal_op), 32'd0);
        check("t5_and_zero", 32'(zero), 32'd0);

        // 6: reset aborts a long SRL
        issue("t6", 4'b1001, 32'hFFFF_FFFF, 32'd20);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("t6_no_result", 32'(out_valid), 32'd0);
            check("t6_idle_ready", 32'(in_ready), 32'd1);
        end

        // Randomized phase: in_valid/out_ready toggle freely, including
        // during shifts, where the request must be ignored.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #2;
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            ALUcontrol = ops[$urandom_range(0, 11)];
            alu_a      = pick();
            alu_b      = pick();
        end

        // Drain
        @(negedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("drain_idle_valid", 32'(out_valid), 32'd0);
        check("drain_idle_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
